// File: rtl/pcpu_exc_pkg.sv
// Shared constants for the exception unit: cause codes, instruction field
// values, CP0 register numbers, Status/Cause bit positions and FSM states.
package pcpu_exc_pkg;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_OV  = 5'd12;

  // Opcode / funct / rs encodings that the unit decodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [4:0] RS_MTC0    = 5'h04;

  localparam logic [31:0] ERET_INSN = 32'h4200_0018;

  // CP0 register numbers
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // Status / Cause bit positions
  localparam int ST_IE   = 0;
  localparam int ST_EXL  = 1;
  localparam int IM_LSB  = 8;
  localparam int EXC_LSB = 2;
  localparam int IP_LSB  = 8;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_TRAP    = 2'd1,
    S_HANDLER = 2'd2,
    S_RET     = 2'd3
  } exc_state_e;

endpackage

// File: rtl/exc_unit_irq_pending.sv
// Interrupt pending logic: rising-edge detect on the IRQ lines, the IP
// register with clear-on-take, and a masked lowest-index priority encoder.
module irq_pending #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] im_i,
  input  logic               take_i,
  output logic [NUM_IRQ-1:0] ip_o,
  output logic               req_o,
  output logic [2:0]         idx_o
);

  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] ip_q;
  logic [NUM_IRQ-1:0] ip_d;
  logic [NUM_IRQ-1:0] masked;
  logic [NUM_IRQ-1:0] clr;

  assign masked = ip_q & im_i;
  assign req_o  = |masked;
  assign ip_o   = ip_q;

  // Lowest-index pending-and-enabled line wins; scan high to low so the last hit is the lowest.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    idx_o = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (masked[k]) idx_o = 3'(k);
    end
  end

  // Clear the winning bit when taken; a fresh rising edge on the same line re-arms it.
  always_comb begin
    clr = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      clr[k] = take_i && (idx_o == 3'(k));
    end
    ip_d = (ip_q & ~clr) | (irq_i & ~prev_q);
  end

  // Edge history and pending bits; edges seen during reset are dropped.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      prev_q <= '0;
      ip_q   <= '0;
    end else begin
      prev_q <= irq_i;
      ip_q   <= ip_d;
    end
  end

endmodule

// File: rtl/exc_unit.sv
// Exception/interrupt unit beside the EX stage: decodes trapping
// instructions, holds Status/Cause/EPC, flushes and redirects the pipeline.
module exc_unit
  import pcpu_exc_pkg::*;
#(
  parameter int          NUM_IRQ  = 4,
  parameter logic [31:0] VEC_ADDR = 32'h0000_0180,
  parameter bit          OVF_ADDI = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        ir_ex_i,
  input  logic [31:0]        pc_ex_i,
  input  logic               valid_ex_i,
  input  logic               ovf_i,
  input  logic [31:0]        wdata_ex_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               flush_o,
  output logic               redirect_o,
  output logic [31:0]        redirect_pc_o,
  output logic [31:0]        status_o,
  output logic [31:0]        cause_o,
  output logic [31:0]        epc_o
);

  exc_state_e state_q, state_d;

  logic        ie_q, exl_q;
  logic [7:0]  im_q;
  logic [4:0]  exc_q;
  logic [31:0] epc_q;

  logic [NUM_IRQ-1:0] ip;
  logic               irq_req;
  logic [2:0]         irq_idx;

  logic        trap_take, int_take, eret_take, mtc0_wr;
  logic [4:0]  code_d;

  // Decode of the EX instruction; a reset cycle behaves like a bubble.
  logic       v;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rd, shamt;
  logic       is_addsub, is_addi, ovf_trap, sys, eret, mtc0, int_req;

  assign v         = valid_ex_i & ~rst;
  assign opcode    = ir_ex_i[31:26];
  assign rs        = ir_ex_i[25:21];
  assign rd        = ir_ex_i[15:11];
  assign shamt     = ir_ex_i[10:6];
  assign funct     = ir_ex_i[5:0];
  assign is_addsub = (opcode == OP_SPECIAL) && (shamt == 5'd0) &&
                     ((funct == FN_ADD) || (funct == FN_SUB));
  assign is_addi   = OVF_ADDI && (opcode == OP_ADDI);
  assign ovf_trap  = v & ovf_i & (is_addsub | is_addi);
  assign sys       = v & (opcode == OP_SPECIAL) & (funct == FN_SYSCALL);
  assign eret      = v & (ir_ex_i == ERET_INSN);
  assign mtc0      = v & (opcode == OP_COP0) & (rs == RS_MTC0);
  assign int_req   = ie_q & ~exl_q & irq_req & v;

  irq_pending #(.NUM_IRQ(NUM_IRQ)) u_irq_pending (
    .clk    (clk),
    .rst    (rst),
    .irq_i  (irq_i),
    .im_i   (im_q[NUM_IRQ-1:0]),
    .take_i (int_take),
    .ip_o   (ip),
    .req_o  (irq_req),
    .idx_o  (irq_idx)
  );

  // Next state and same-cycle flush/redirect; priority eret > ovf > sys > int.
  always_comb begin
    state_d       = state_q;
    trap_take     = 1'b0;
    int_take      = 1'b0;
    eret_take     = 1'b0;
    code_d        = exc_q;
    flush_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    case (state_q)
      S_RUN: begin
        if (ovf_trap) begin
          trap_take = 1'b1;
          code_d    = EXC_OV;
        end else if (sys) begin
          trap_take = 1'b1;
          code_d    = EXC_SYS;
        end else if (int_req) begin
          trap_take = 1'b1;
          int_take  = 1'b1;
          code_d    = EXC_INT;
        end
        if (trap_take) state_d = S_TRAP;
      end
      S_HANDLER: begin
        if (eret) begin
          eret_take = 1'b1;
          state_d   = S_RET;
        end else if (ovf_trap) begin
          trap_take = 1'b1;
          code_d    = EXC_OV;
          state_d   = S_TRAP;
        end else if (sys) begin
          trap_take = 1'b1;
          code_d    = EXC_SYS;
          state_d   = S_TRAP;
        end
      end
      S_TRAP:  state_d = S_HANDLER;
      S_RET:   state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
    if (trap_take) begin
      flush_o       = 1'b1;
      redirect_o    = 1'b1;
      redirect_pc_o = VEC_ADDR;
    end else if (eret_take) begin
      flush_o       = 1'b1;
      redirect_o    = 1'b1;
      redirect_pc_o = epc_q;
    end
  end

  // mtc0 commits only where decode is live and the instruction is not cancelled.
  assign mtc0_wr = mtc0 & ((state_q == S_RUN) | (state_q == S_HANDLER)) &
                   ~trap_take & ~eret_take;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // CP0 registers: trap entry beats eret, which beats a software write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q  <= 1'b0;
      exl_q <= 1'b0;
      im_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else if (trap_take) begin
      exc_q <= code_d;
      exl_q <= 1'b1;
      if (!exl_q) epc_q <= pc_ex_i;
    end else if (eret_take) begin
      exl_q <= 1'b0;
    end else if (mtc0_wr) begin
      if (rd == CP0_STATUS) begin
        ie_q <= wdata_ex_i[ST_IE];
        im_q <= wdata_ex_i[IM_LSB +: 8];
      end else if (rd == CP0_EPC) begin
        epc_q <= wdata_ex_i;
      end
    end
  end

  // Architectural views of Status and Cause.
  always_comb begin
    status_o                = '0;
    status_o[ST_IE]         = ie_q;
    status_o[ST_EXL]        = exl_q;
    status_o[IM_LSB +: 8]   = im_q;
    cause_o                 = '0;
    cause_o[EXC_LSB +: 5]   = exc_q;
    cause_o[IP_LSB +: 8]    = 8'(ip);
  end

  assign epc_o = epc_q;

endmodule
